// File: rtl/fifo_drain_arbiter_if.sv
// Source-side and consumer-side signals of one FIFO tree merge node.
// The arbiter takes the master modport; the FIFO buffers and the consumer sit on the slave side.
interface fifo_drain_arbiter_if #(
    parameter int DATA_WIDTH = 36,
    parameter int NUM_SRC    = 2,
    parameter int SRC_BITS   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i;
    logic [NUM_SRC-1:0]            src_valid_i;
    logic [NUM_SRC-1:0]            src_empty_i;
    logic [NUM_SRC-1:0]            src_read_en_o;
    logic [DATA_WIDTH-1:0]         out_data_o;
    logic [SRC_BITS-1:0]           out_src_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          err_o;

    modport master (
        input  src_data_i, src_valid_i, src_empty_i, out_ready_i,
        output src_read_en_o, out_data_o, out_src_o, out_valid_o, err_o
    );

    modport slave (
        output src_data_i, src_valid_i, src_empty_i, out_ready_i,
        input  src_read_en_o, out_data_o, out_src_o, out_valid_o, err_o
    );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_SRC FIFO buffers into a single valid/ready stream.
// Each grant is a one-cycle read strobe followed by a capture on the source's registered valid.
module fifo_drain_arbiter #(
    parameter int DATA_WIDTH = 36,
    parameter int NUM_SRC    = 2,
    parameter int SRC_BITS   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_drain_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [SRC_BITS-1:0]   last_q, last_d;
    logic [SRC_BITS-1:0]   grant_q, grant_d;
    logic [NUM_SRC-1:0]    rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SRC_BITS-1:0]   out_src_q, out_src_d;
    logic                  err_q, err_d;

    logic                  any_avail;
    logic [SRC_BITS-1:0]   next_grant;

    // Nearest non-empty index after `last`, wrapping, with `last` itself tried last.
    // Scanning from the farthest candidate down lets the nearest one overwrite the result.
    function automatic logic [SRC_BITS-1:0] rr_pick(
        input logic [SRC_BITS-1:0] last,
        input logic [NUM_SRC-1:0]  empty
    );
        logic [SRC_BITS-1:0] pick;
        int                  idx;
        pick = last;
        for (int step = NUM_SRC; step >= 1; step--) begin
            idx = (int'(last) + step) % NUM_SRC;
            if (!empty[idx[SRC_BITS-1:0]]) begin
                pick = idx[SRC_BITS-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_BITS-1:0] idx);
        logic [NUM_SRC-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    assign any_avail  = ~&bus.src_empty_i;
    assign next_grant = rr_pick(last_q, bus.src_empty_i);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        rd_en_d    = '0;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (any_avail) begin
                    grant_d = next_grant;
                    rd_en_d = onehot(next_grant);
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Rotation advances past g whether or not the source answered.
                last_d = grant_q;
                if (bus.src_valid_i[grant_q]) begin
                    out_data_d = bus.src_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                    out_src_d  = grant_q;
                    state_d    = S_OUTPUT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready_i) begin
                    if (any_avail) begin
                        grant_d = next_grant;
                        rd_en_d = onehot(next_grant);
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_q     <= SRC_BITS'(NUM_SRC - 1);
            grant_q    <= '0;
            rd_en_q    <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            rd_en_q    <= rd_en_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            err_q      <= err_d;
        end
    end

    assign bus.src_read_en_o = rd_en_q;
    assign bus.out_valid_o   = (state_q == S_OUTPUT);
    assign bus.out_data_o    = out_data_q;
    assign bus.out_src_o     = out_src_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: queue-based FIFO sources, round-robin grant predictor
// and an expected-transfer scoreboard, driven by directed scenarios and a random phase.
module tb_fifo_drain_arbiter;

    localparam int DW = 36;
    localparam int NS = 4;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_drain_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

    fifo_drain_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [SB-1:0] src;
        logic [DW-1:0] data;
    } xfer_t;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] srcq [NS][$];
    xfer_t         exp_q [$];
    int            hs_cyc [$];
    int            hs_src [$];

    logic          ready_next;
    logic [NS-1:0] rd_seen;
    logic          rd_drop;
    logic          drop_arm;
    logic [NS-1:0] empty_prev;
    logic          hs_prev;
    logic          stall_prev;
    logic [DW-1:0] data_prev;
    logic [SB-1:0] src_prev;
    int            model_last;
    logic          err_exp;
    int            err_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Which source a fresh grant must go to, straight from the rotation rule.
    function automatic int rr_expect(input int last, input logic [NS-1:0] empty);
        for (int d = 1; d <= NS; d++) begin
            if (!empty[(last + d) % NS]) return (last + d) % NS;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = {4'($urandom_range(0, 15)), 32'($urandom())};
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_last = NS - 1;
        err_exp    = 1'b0;
        err_pend   = 0;
        rd_seen    = '0;
        rd_drop    = 1'b0;
        hs_prev    = 1'b0;
        stall_prev = 1'b0;
        empty_prev = '1;
    endtask

    // FIFO source behaviour: a strobe seen last cycle pops a word and presents it with valid now.
    task automatic drive_sources();
        logic [NS*DW-1:0] d;
        logic [NS-1:0]    v;
        logic [DW-1:0]    w;
        for (int b = 0; b < NS*DW; b++) d[b] = 1'($urandom_range(0, 1));
        v = NS'($urandom_range(0, (1 << NS) - 1));
        for (int k = 0; k < NS; k++) begin
            if (rd_seen[k] && srcq[k].size() > 0) begin
                w = srcq[k].pop_front();
                v[k] = !rd_drop;
                if (!rd_drop) d[k*DW +: DW] = w;
            end
        end
        bus.src_data_i  = d;
        bus.src_valid_i = v;
        for (int k = 0; k < NS; k++) bus.src_empty_i[k] = (srcq[k].size() == 0);
        bus.out_ready_i = ready_next;
        rd_seen = '0;
    endtask

    task automatic sample();
        logic [NS-1:0] rd;
        logic          hs;
        int            g;
        int            e;
        xfer_t         x;
        rd = bus.src_read_en_o;
        chk("rd_onehot", 64'($countones(rd) <= 1), 64'd1);
        if (hs_prev && empty_prev != '1) chk("rd_after_hs", 64'(rd != '0), 64'd1);
        if (err_pend > 0) begin
            err_pend--;
            if (err_pend == 0) err_exp = 1'b1;
        end
        if (rd != '0) begin
            g = 0;
            for (int k = NS - 1; k >= 0; k--) if (rd[k]) g = k;
            e = rr_expect(model_last, empty_prev);
            chk("rd_grant", 64'(g), 64'(e));
            chk("rd_nonempty", 64'(empty_prev[g]), 64'd0);
            chk("rd_no_stall", 64'(stall_prev), 64'd0);
            model_last = g;
            rd_drop = 1'b0;
            if (srcq[g].size() > 0) begin
                if (drop_arm) begin
                    rd_drop  = 1'b1;
                    drop_arm = 1'b0;
                    err_pend = 2;
                end else begin
                    exp_q.push_back('{src: SB'(g), data: srcq[g][0]});
                end
            end
        end
        rd_seen = rd;
        chk("err", 64'(bus.err_o), 64'(err_exp));
        if (stall_prev) begin
            chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
            chk("hold_data", 64'(bus.out_data_o), 64'(data_prev));
            chk("hold_src", 64'(bus.out_src_o), 64'(src_prev));
        end
        if (exp_q.size() == 0) chk("spurious_valid", 64'(bus.out_valid_o), 64'd0);
        hs = bus.out_valid_o && bus.out_ready_i;
        if (hs && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("out_src", 64'(bus.out_src_o), 64'(x.src));
            chk("out_data", 64'(bus.out_data_o), 64'(x.data));
            hs_cyc.push_back(cyc);
            hs_src.push_back(int'(bus.out_src_o));
        end
        stall_prev = bus.out_valid_o && !bus.out_ready_i;
        hs_prev    = hs;
        data_prev  = bus.out_data_o;
        src_prev   = bus.out_src_o;
        empty_prev = bus.src_empty_i;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_sources();
        cyc++;
        @(negedge clk);
        sample();
    endtask

    initial begin
        int k;
        int n;
        reset           = 1'b1;
        bus.src_empty_i = '1;
        bus.src_valid_i = '0;
        bus.src_data_i  = '0;
        bus.out_ready_i = 1'b0;
        ready_next      = 1'b0;
        drop_arm        = 1'b0;
        model_reset();

        // Reset / idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", 64'(bus.src_read_en_o), 64'd0);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_data", 64'(bus.out_data_o), 64'd0);
        chk("rst_src", 64'(bus.out_src_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        reset = 1'b0;
        repeat (10) cycle();
        chk("idle_rd_en", 64'(bus.src_read_en_o), 64'd0);
        chk("idle_valid", 64'(bus.out_valid_o), 64'd0);

        // Single word from source 1
        ready_next = 1'b1;
        srcq[1].push_back(36'h0_0000_00A5);
        cycle(); chk("sw_c0_rd", 64'(bus.src_read_en_o), 64'd0);
        cycle(); chk("sw_c1_rd", 64'(bus.src_read_en_o), 64'b0010);
        cycle(); chk("sw_c2_rd", 64'(bus.src_read_en_o), 64'd0);
                 chk("sw_c2_valid", 64'(bus.out_valid_o), 64'd0);
        cycle(); chk("sw_c3_valid", 64'(bus.out_valid_o), 64'd1);
                 chk("sw_c3_data", 64'(bus.out_data_o), 64'h0A5);
                 chk("sw_c3_src", 64'(bus.out_src_o), 64'd1);
        cycle(); chk("sw_c4_valid", 64'(bus.out_valid_o), 64'd0);

        // Backpressure: hold 36'h123 for 7 cycles while another source waits
        ready_next = 1'b0;
        srcq[2].push_back(36'h123);
        n = 0;
        while (!bus.out_valid_o && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_reach_output", 64'(bus.out_valid_o), 64'd1);
        srcq[0].push_back(rand_word());
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cycle();
            chk("bp_data", 64'(bus.out_data_o), 64'h123);
            chk("bp_rd", 64'(bus.src_read_en_o), 64'd0);
        end
        ready_next = 1'b1;
        cycle();
        chk("bp_xfer_valid", 64'(bus.out_valid_o), 64'd1);
        chk("bp_xfer_data", 64'(bus.out_data_o), 64'h123);
        cycle();
        chk("bp_next_rd", 64'(bus.src_read_en_o), 64'b0001);
        repeat (4) cycle();

        // Missing valid on source 1, then source 2 must be served
        hs_src.delete();
        drop_arm = 1'b1;
        srcq[1].push_back(rand_word());
        srcq[2].push_back(36'h0_0000_BEEF);
        repeat (12) cycle();
        chk("mv_err", 64'(bus.err_o), 64'd1);
        chk("mv_count", 64'(hs_src.size()), 64'd1);
        if (hs_src.size() > 0) chk("mv_next_src", 64'(hs_src[0]), 64'd2);

        // Asynchronous reset while in WAIT
        srcq[0].push_back(rand_word());
        n = 0;
        while (bus.src_read_en_o == '0 && n < 10) begin
            cycle();
            n++;
        end
        chk("ar_reach_read", 64'(bus.src_read_en_o != '0), 64'd1);
        cycle();
        #1 reset = 1'b1;
        #1;
        chk("ar_rd_en", 64'(bus.src_read_en_o), 64'd0);
        chk("ar_valid", 64'(bus.out_valid_o), 64'd0);
        chk("ar_err", 64'(bus.err_o), 64'd0);
        #1 reset = 1'b0;
        model_reset();

        // Round robin: 4 sources x 3 words, first grant must be source 0
        hs_src.delete();
        hs_cyc.delete();
        ready_next = 1'b1;
        for (int s = 0; s < NS; s++) begin
            for (int j = 0; j < 3; j++) srcq[s].push_back(rand_word());
        end
        n = 0;
        while (hs_src.size() < 12 && n < 80) begin
            cycle();
            n++;
        end
        chk("rr_count", 64'(hs_src.size()), 64'd12);
        for (int i = 0; i < hs_src.size(); i++) begin
            chk("rr_src", 64'(hs_src[i]), 64'(i % NS));
            if (i > 0) chk("rr_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
        end
        chk("rr_err", 64'(bus.err_o), 64'd0);

        // Random traffic, backpressure and occasional missing valids
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, NS - 1));
                if (srcq[k].size() < 4) srcq[k].push_back(rand_word());
            end
            ready_next = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) drop_arm = 1'b1;
            cycle();
        end
        drop_arm   = 1'b0;
        ready_next = 1'b1;
        repeat (80) cycle();
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        n = 0;
        for (int s = 0; s < NS; s++) n += srcq[s].size();
        chk("drain_sources", 64'(n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin reader that drains NUM_SRC FIFO buffers of the FIFO tree and forwards one word at a time to a downstream consumer over a valid/ready handshake. Each buffer is popped with a single-cycle read strobe, and its data is taken on the registered valid flag that follows one cycle later. The block sits at every merge node of the FIFO tree and at the tree root, where it feeds the clause evaluator.

## Interface
- DATA_WIDTH, 36, width of one buffered word.
- NUM_SRC, 2, number of source FIFO buffers (2..8).
- SRC_BITS, $clog2(NUM_SRC) (min 1), width of the source index.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- src_data_i  in  NUM_SRC*DATA_WIDTH  per-source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_valid_i  in  NUM_SRC  per-source data-valid; high the cycle after a granted read.
- src_empty_i  in  NUM_SRC  per-source empty flag.
- src_read_en_o  out  NUM_SRC  registered one-hot read strobe.
- out_data_o  out  DATA_WIDTH  forwarded word.
- out_src_o  out  SRC_BITS  index of the source that supplied out_data_o.
- out_valid_o  out  1  out_data_o/out_src_o valid.
- out_ready_i  in  1  consumer accepts the word this cycle.
- err_o  out  1  sticky; set when a granted read returns no valid.

## Operation
- Grant pointer `last` (SRC_BITS). The next grant is the first index with src_empty_i low, searching last+1, last+2, ... with modulo-NUM_SRC wrap. The search includes `last` itself as the final candidate.
- FSM states:
  - IDLE
    - If any source is non-empty: latch grant g, drive src_read_en_o = one-hot(g) next cycle, and go to READ.
    - Otherwise stay in IDLE.
  - READ
    - src_read_en_o[g] is high for exactly this cycle.
    - Go to WAIT.
  - WAIT
    - src_read_en_o = 0.
    - If src_valid_i[g] = 1: capture the g slice of src_data_i into out_data_o, set out_src_o = g, set last = g, and go to OUTPUT.
    - Otherwise: set err_o, set last = g, and go to IDLE.
  - OUTPUT
    - out_valid_o = 1.
    - out_data_o and out_src_o are held stable until the handshake.
    - On out_valid_o && out_ready_i: if any source is non-empty in that same cycle, latch the next grant and go directly to READ; otherwise go to IDLE.
- src_valid_i from non-granted sources, and from any source outside WAIT, is ignored.
- At most one bit of src_read_en_o is high in any cycle. A read is never issued to a source whose src_empty_i was high in the selecting cycle.
- err_o clears only on reset.

## Timing
- Reset values: state IDLE, last = NUM_SRC-1 (so the first grant searches from index 0), src_read_en_o = 0, out_valid_o = 0, out_data_o = 0, out_src_o = 0, err_o = 0.
- Latency: from src_empty_i low in IDLE (cycle 0) to out_valid_o high is 3 cycles.
  - READ in cycle 1, WAIT in cycle 2, OUTPUT in cycle 3.
- Sustained throughput with out_ready_i held high is 1 word per 3 cycles, via OUTPUT -> READ.
- out_ready_i low stalls OUTPUT indefinitely. No read is issued during a stall.
- Asserting reset mid-operation clears all outputs immediately, without waiting for a clock edge. An in-flight word is discarded, and the next grant after release starts from index 0.
- Simultaneous non-empty sources are served in strict rotation. A single non-empty source is served back to back.

## Test plan
- Reset/idle:
  - Stimulus: assert reset with all src_empty_i = 1, then release it.
  - Required response: all outputs 0. After 10 cycles, src_read_en_o is still 0 and out_valid_o is still 0.
- Single word:
  - Stimulus: source 1 non-empty holding 36'h0_0000_00A5, out_ready_i = 1.
  - Required response: src_read_en_o = 2'b10 for exactly one cycle. out_valid_o is high 3 cycles after selection with out_data_o = 36'hA5 and out_src_o = 1.
- Round robin:
  - Stimulus: NUM_SRC = 4, all sources holding 3 words each, out_ready_i = 1.
  - Required response: out_src_o sequence is 0,1,2,3,0,1,2,3,0,1,2,3; words are spaced 3 cycles apart; err_o stays 0.
- Backpressure:
  - Stimulus: out_ready_i = 0 for 7 cycles while OUTPUT holds word 36'h123.
  - Required response: out_data_o is stable at 36'h123 and src_read_en_o = 0 throughout. The word transfers in the cycle out_ready_i rises.
- Missing valid:
  - Stimulus: a source model returns src_valid_i = 0 after a granted read.
  - Required response: err_o = 1 from the next cycle, no out_valid_o for that grant, and the next grant goes to the following non-empty source.
- Async reset mid-transfer:
  - Stimulus: pulse reset between clock edges while in WAIT.
  - Required response: src_read_en_o, out_valid_o and err_o are 0 before the next edge. After release, the first grant goes to the lowest-index non-empty source.
